// File: rtl/key_reader.sv
// key_reader: Avalon-MM slave for board push-buttons.
// Each key is synchronised, converted to logical polarity (1 = pressed) and
// debounced. Press events latch into a write-1-to-clear EDGE register; a
// level interrupt is raised while any event enabled by MASK is pending.
//
// Bus handshake: a read is accepted when avs_cs & avs_rd is high at a rising
// edge and its data is held on avs_rdd from the next edge until another read
// is accepted; a write is accepted when avs_cs & avs_wr is high at a rising
// edge and takes effect at that edge. There are no wait states.
module key_reader #(
  parameter int KEY_WIDTH       = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic                 csi_clk,
  input  logic                 csi_rst_n,
  input  logic                 avs_cs,
  input  logic [4:0]           avs_add,
  input  logic                 avs_rd,
  input  logic                 avs_wr,
  input  logic [31:0]          avs_wrd,
  output logic [31:0]          avs_rdd,
  input  logic [KEY_WIDTH-1:0] coe_KEY,
  output logic                 ins_irq
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  // Synchroniser reset level equals a released pin, so reset never looks
  // like a press.
  localparam logic [KEY_WIDTH-1:0] PIN_RELEASED = (ACTIVE_LOW != 0) ? '1 : '0;

  localparam logic [4:0] ADDR_STATE = 5'd0;
  localparam logic [4:0] ADDR_EDGE  = 5'd1;
  localparam logic [4:0] ADDR_MASK  = 5'd2;
  localparam logic [4:0] ADDR_RAW   = 5'd3;

  logic [KEY_WIDTH-1:0] sync_meta;
  logic [KEY_WIDTH-1:0] sync_q;
  logic [KEY_WIDTH-1:0] raw;
  logic [KEY_WIDTH-1:0] deb;
  logic [KEY_WIDTH-1:0] deb_next;
  logic [KEY_WIDTH-1:0] press;
  logic [KEY_WIDTH-1:0] edge_q;
  logic [KEY_WIDTH-1:0] mask_q;
  logic [KEY_WIDTH-1:0] wdata_k;
  logic [KEY_WIDTH-1:0] edge_clr;
  logic [31:0]          rd_mux;
  logic                 rd_en;
  logic                 wr_en;

  assign rd_en   = avs_cs & avs_rd;
  assign wr_en   = avs_cs & avs_wr;
  assign wdata_k = avs_wrd[KEY_WIDTH-1:0];

  // Two-flop synchroniser on the raw asynchronous pins.
  always_ff @(posedge csi_clk or negedge csi_rst_n) begin
    if (!csi_rst_n) begin
      sync_meta <= PIN_RELEASED;
      sync_q    <= PIN_RELEASED;
    end else begin
      sync_meta <= coe_KEY;
      sync_q    <= sync_meta;
    end
  end

  assign raw = (ACTIVE_LOW != 0) ? ~sync_q : sync_q;

  // Per-key debounce: count consecutive cycles that raw disagrees with the
  // accepted state, and accept the new level on the last counted cycle.
  for (genvar i = 0; i < KEY_WIDTH; i++) begin : g_deb
    logic [CW-1:0] cnt;
    logic          hit;

    assign hit         = (raw[i] != deb[i]) && (cnt == CNT_LAST);
    assign deb_next[i] = hit ? raw[i] : deb[i];

    // Counter runs only while raw differs and restarts after each accept.
    always_ff @(posedge csi_clk or negedge csi_rst_n) begin
      if (!csi_rst_n) begin
        cnt <= '0;
      end else if ((raw[i] != deb[i]) && !hit) begin
        cnt <= cnt + CW'(1);
      end else begin
        cnt <= '0;
      end
    end
  end

  // A press is the debounced state rising; releases are not recorded.
  assign press    = deb_next & ~deb;
  assign edge_clr = (wr_en && (avs_add == ADDR_EDGE)) ? wdata_k : '0;

  // Debounced state, event capture (set beats clear) and interrupt mask.
  always_ff @(posedge csi_clk or negedge csi_rst_n) begin
    if (!csi_rst_n) begin
      deb    <= '0;
      edge_q <= '0;
      mask_q <= '0;
    end else begin
      deb    <= deb_next;
      edge_q <= (edge_q & ~edge_clr) | press;
      if (wr_en && (avs_add == ADDR_MASK)) begin
        mask_q <= wdata_k;
      end
    end
  end

  // Read multiplexer over the pre-write register contents.
  always_comb begin
    rd_mux = '0;
    case (avs_add)
      ADDR_STATE: rd_mux[KEY_WIDTH-1:0] = deb;
      ADDR_EDGE:  rd_mux[KEY_WIDTH-1:0] = edge_q;
      ADDR_MASK:  rd_mux[KEY_WIDTH-1:0] = mask_q;
      ADDR_RAW:   rd_mux[KEY_WIDTH-1:0] = raw;
      default:    rd_mux = '0;
    endcase
  end

  // Registered read data (held between reads) and registered interrupt.
  always_ff @(posedge csi_clk or negedge csi_rst_n) begin
    if (!csi_rst_n) begin
      avs_rdd <= '0;
      ins_irq <= 1'b0;
    end else begin
      if (rd_en) begin
        avs_rdd <= rd_mux;
      end
      ins_irq <= |(edge_q & mask_q);
    end
  end

endmodule

// File: tb/tb_key_reader.sv
// tb_key_reader: table-driven register checks, hand-written timing sequences
// and a randomized run compared against a behavioural model of key_reader.
module tb_key_reader;

  localparam int KW = 4;
  localparam int DB = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        avs_cs = 1'b0;
  logic [4:0]  avs_add = '0;
  logic        avs_rd = 1'b0;
  logic        avs_wr = 1'b0;
  logic [31:0] avs_wrd = '0;
  logic [31:0] avs_rdd;
  logic [KW-1:0] coe_key = 4'hF;
  logic        ins_irq;

  int checks = 0;
  int errors = 0;

  // Clock / reset block
  always #5 clk = ~clk;

  key_reader #(.KEY_WIDTH(KW), .DEBOUNCE_CYCLES(DB), .ACTIVE_LOW(1)) dut (
    .csi_clk(clk), .csi_rst_n(rst_n),
    .avs_cs(avs_cs), .avs_add(avs_add), .avs_rd(avs_rd), .avs_wr(avs_wr),
    .avs_wrd(avs_wrd), .avs_rdd(avs_rdd),
    .coe_KEY(coe_key), .ins_irq(ins_irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Behavioural model: pins seen two samples late; a key's accepted level
  // flips once the last DB samples all disagree with it.
  logic [3:0]  pin_q[$] = '{4'h0, 4'h0};
  logic [7:0]  m_hist[KW] = '{default: 8'h00};
  logic [3:0]  m_deb = '0;
  logic [3:0]  m_edge = '0;
  logic [3:0]  m_mask = '0;
  logic        m_irq = 1'b0;
  logic [31:0] m_rdd = '0;
  logic [31:0] exp_q[$];

  always @(posedge clk or negedge rst_n) begin : model
    logic [3:0]  raw_b;
    logic [3:0]  new_deb;
    logic [3:0]  press;
    logic [31:0] rv;
    if (!rst_n) begin
      pin_q  = '{4'h0, 4'h0};
      for (int k = 0; k < KW; k++) m_hist[k] = 8'h00;
      m_deb  = '0;
      m_edge = '0;
      m_mask = '0;
      m_irq  = 1'b0;
      m_rdd  = '0;
      exp_q.delete();
    end else begin
      raw_b = pin_q[0];
      rv = 32'h0;
      if (avs_add == 5'd0) rv = {28'h0, m_deb};
      else if (avs_add == 5'd1) rv = {28'h0, m_edge};
      else if (avs_add == 5'd2) rv = {28'h0, m_mask};
      else if (avs_add == 5'd3) rv = {28'h0, raw_b};
      if (avs_cs && avs_rd) exp_q.push_back(rv);
      m_irq = |(m_edge & m_mask);
      new_deb = m_deb;
      for (int k = 0; k < KW; k++) begin
        m_hist[k] = {m_hist[k][6:0], raw_b[k]};
        if (m_hist[k] == {8{~m_deb[k]}}) new_deb[k] = ~m_deb[k];
      end
      press = new_deb & ~m_deb;
      if (avs_cs && avs_wr && avs_add == 5'd1) m_edge = m_edge & ~avs_wrd[3:0];
      if (avs_cs && avs_wr && avs_add == 5'd2) m_mask = avs_wrd[3:0];
      m_edge = m_edge | press;
      m_deb = new_deb;
      void'(pin_q.pop_front());
      pin_q.push_back(~coe_key);
    end
  end

  // Scoreboard: compare outputs against the model on every falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) m_rdd = exp_q.pop_front();
    check("model_rdd", avs_rdd, m_rdd);
    check("model_irq", {31'h0, ins_irq}, {31'h0, m_irq});
  end

  // Driver tasks
  task automatic bus_idle();
    avs_cs = 1'b0; avs_rd = 1'b0; avs_wr = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk);
    avs_cs = 1'b1; avs_rd = 1'b1; avs_wr = 1'b0; avs_add = a;
    @(negedge clk);
    d = avs_rdd;
    bus_idle();
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] wd);
    @(negedge clk);
    avs_cs = 1'b1; avs_rd = 1'b0; avs_wr = 1'b1; avs_add = a; avs_wrd = wd;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic read_check(input string name, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check(name, d, exp);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (cycles) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  typedef struct {
    logic        wr;
    logic [4:0]  add;
    logic [31:0] wd;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vq[$];

  task automatic add_vec(input logic wr, input logic [4:0] a, input logic [31:0] wd,
                         input logic [31:0] exp, input string nm);
    vec_t v;
    v.wr = wr; v.add = a; v.wd = wd; v.exp = exp; v.name = nm;
    vq.push_back(v);
  endtask

  int cd[KW];
  int found_k;

  initial begin
    // Reset with every key released
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("rst_rdd", avs_rdd, 32'h0);
    check("rst_irq", {31'h0, ins_irq}, 32'h0);
    repeat (50) @(negedge clk);
    read_check("rst_state", 5'd0, 32'h0);
    read_check("rst_edge", 5'd1, 32'h0);
    read_check("rst_mask", 5'd2, 32'h0);

    // Register access table (keys idle)
    add_vec(1'b1, 5'd2,  32'hFFFF_FFFF, 32'hF, "tbl_mask_all");
    add_vec(1'b1, 5'd2,  32'h0000_000A, 32'hA, "tbl_mask_a");
    add_vec(1'b1, 5'd2,  32'hFFFF_FFF0, 32'h0, "tbl_mask_hi_only");
    add_vec(1'b1, 5'd0,  32'hFFFF_FFFF, 32'h0, "tbl_state_ro");
    add_vec(1'b1, 5'd3,  32'hFFFF_FFFF, 32'h0, "tbl_raw_ro");
    add_vec(1'b1, 5'd1,  32'h0000_000F, 32'h0, "tbl_edge_w1c_idle");
    add_vec(1'b1, 5'd7,  32'h0000_00FF, 32'h0, "tbl_unmapped7");
    add_vec(1'b0, 5'd31, 32'h0,         32'h0, "tbl_unmapped31");
    add_vec(1'b1, 5'd2,  32'h0000_0005, 32'h5, "tbl_mask_5");
    add_vec(1'b0, 5'd2,  32'h0,         32'h5, "tbl_mask_keep");
    add_vec(1'b1, 5'd2,  32'h0,         32'h0, "tbl_mask_clr");
    foreach (vq[i]) begin
      if (vq[i].wr) bus_write(vq[i].add, vq[i].wd);
      read_check(vq[i].name, vq[i].add, vq[i].exp);
    end

    // Clean press of key 0: RAW after 2 cycles, STATE/EDGE 10 cycles after pin
    @(negedge clk);
    coe_key[0] = 1'b0;
    avs_cs = 1'b1; avs_rd = 1'b1; avs_add = 5'd3;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k <= 3) check($sformatf("press_raw_k%0d", k), avs_rdd, (k == 3) ? 32'h1 : 32'h0);
      else check($sformatf("press_state_k%0d", k), avs_rdd, (k == 11) ? 32'h1 : 32'h0);
      avs_add = (k < 3) ? 5'd3 : (k < 11) ? 5'd0 : 5'd1;
    end
    @(negedge clk);
    check("press_edge", avs_rdd, 32'h1);
    bus_idle();

    // 5-cycle glitch on key 1 never reaches STATE or EDGE
    @(negedge clk);
    coe_key[1] = 1'b0;
    avs_cs = 1'b1; avs_rd = 1'b1; avs_add = 5'd0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 5) coe_key[1] = 1'b1;
      check($sformatf("glitch_state_k%0d", k), avs_rdd, 32'h1);
    end
    bus_idle();
    read_check("glitch_edge", 5'd1, 32'h1);

    // Release produces no event; clear events
    coe_key[0] = 1'b1;
    repeat (15) @(negedge clk);
    read_check("release_edge", 5'd1, 32'h1);
    read_check("release_state", 5'd0, 32'h0);
    bus_write(5'd1, 32'hF);
    read_check("clear_edge", 5'd1, 32'h0);

    // Masked interrupt: rise one cycle after EDGE[0], fall one cycle after W1C
    bus_write(5'd2, 32'h1);
    @(negedge clk);
    coe_key[0] = 1'b0;
    avs_cs = 1'b1; avs_rd = 1'b1; avs_add = 5'd1;
    found_k = 0;
    for (int k = 1; k <= 20 && found_k == 0; k++) begin
      @(negedge clk);
      if (avs_rdd[0]) found_k = k;
      else check($sformatf("irq_low_k%0d", k), {31'h0, ins_irq}, 32'h0);
    end
    check("irq_edge_seen_cycle", found_k, 11);
    check("irq_rise", {31'h0, ins_irq}, 32'h1);
    avs_rd = 1'b0; avs_wr = 1'b1; avs_wrd = 32'h1;
    @(negedge clk);
    bus_idle();
    check("irq_hold_after_w1c", {31'h0, ins_irq}, 32'h1);
    @(negedge clk);
    check("irq_fall", {31'h0, ins_irq}, 32'h0);
    read_check("irq_edge_cleared", 5'd1, 32'h0);
    coe_key[0] = 1'b1;
    repeat (15) @(negedge clk);

    // Unmasked key 2 leaves the interrupt low
    coe_key[2] = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      check($sformatf("unmasked_irq_k%0d", k), {31'h0, ins_irq}, 32'h0);
    end
    read_check("unmasked_edge", 5'd1, 32'h4);
    read_check("unmasked_state", 5'd0, 32'h4);
    coe_key[2] = 1'b1;
    repeat (15) @(negedge clk);
    bus_write(5'd1, 32'hF);

    // W1C on EDGE[3] in the cycle key 3's press is accepted: set wins
    @(negedge clk);
    coe_key[3] = 1'b0;
    repeat (9) @(negedge clk);
    avs_cs = 1'b1; avs_wr = 1'b1; avs_add = 5'd1; avs_wrd = 32'h8;
    @(negedge clk);
    bus_idle();
    read_check("race_edge_set_wins", 5'd1, 32'h8);
    bus_write(5'd1, 32'h8);
    read_check("race_edge_then_clear", 5'd1, 32'h0);

    // Unmapped read and write to read-only STATE
    read_check("unmapped_read7", 5'd7, 32'h0);
    bus_write(5'd0, 32'hFFFF_FFFF);
    read_check("state_after_write", 5'd0, 32'h8);
    coe_key[3] = 1'b1;
    repeat (15) @(negedge clk);
    bus_write(5'd1, 32'hF);

    // Reset while key 1 is held: state clears, key re-accepted as a new press
    coe_key[1] = 1'b0;
    repeat (15) @(negedge clk);
    read_check("pre_reset_edge", 5'd1, 32'h2);
    bus_write(5'd2, 32'h2);
    @(negedge clk);
    check("pre_reset_irq", {31'h0, ins_irq}, 32'h1);
    do_reset(3);
    check("mid_reset_irq", {31'h0, ins_irq}, 32'h0);
    check("mid_reset_rdd", avs_rdd, 32'h0);
    read_check("post_reset_state", 5'd0, 32'h0);
    read_check("post_reset_edge", 5'd1, 32'h0);
    repeat (12) @(negedge clk);
    read_check("fresh_press_state", 5'd0, 32'h2);
    read_check("fresh_press_edge", 5'd1, 32'h2);
    read_check("fresh_press_mask", 5'd2, 32'h0);
    coe_key[1] = 1'b1;
    repeat (15) @(negedge clk);

    // Randomized run against the model
    for (int k = 0; k < KW; k++) cd[k] = $urandom_range(1, 20);
    for (int c = 0; c < 2500; c++) begin
      if (c == 1200) begin
        bus_idle();
        do_reset(2);
      end
      @(negedge clk);
      for (int k = 0; k < KW; k++) begin
        if (cd[k] == 0) begin
          coe_key[k] = ~coe_key[k];
          cd[k] = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 6) : $urandom_range(9, 25);
        end else begin
          cd[k]--;
        end
      end
      avs_cs  = ($urandom_range(0, 3) != 0);
      avs_rd  = $urandom_range(0, 1) == 1;
      avs_wr  = ($urandom_range(0, 2) == 0);
      avs_add = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(4, 31)) : 5'($urandom_range(0, 3));
      avs_wrd = $urandom;
    end
    bus_idle();
    coe_key = 4'hF;
    repeat (20) @(negedge clk);

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
